// File: rtl/i2s_master_rx_if.sv
// I2S receiver bus: microphone pins, capture request and the sample
// stream delivered to the defect-analysis buffer.
interface i2s_master_rx_if #(
    parameter int DATA_BITS = 8,
    parameter int IDX_W     = 12
);
    logic                 start_i;
    logic                 sd_i;
    logic                 sck_o;
    logic                 ws_o;
    logic                 LR_o;
    logic [DATA_BITS-1:0] sample_o;
    logic                 sample_valid_o;
    logic [IDX_W-1:0]     sample_idx_o;
    logic                 busy_o;
    logic                 done_o;

    modport master (
        input  start_i, sd_i,
        output sck_o, ws_o, LR_o, sample_o, sample_valid_o, sample_idx_o, busy_o, done_o
    );

    modport slave (
        output start_i, sd_i,
        input  sck_o, ws_o, LR_o, sample_o, sample_valid_o, sample_idx_o, busy_o, done_o
    );
endinterface

// File: rtl/i2s_master_rx.sv
// I2S master receiver: free-running sck/ws generation and burst capture
// of the left-channel sample from an I2S microphone.
//
// state | meaning
// IDLE  | no capture in progress, waiting for start
// ARM   | waiting for the ws fall that opens the next left slot
// SHIFT | shifting data bits in on each sck falling edge
// EMIT  | presenting the assembled sample with its index
// DONE  | one-cycle end-of-burst strobe, index rewinds to 0
module i2s_master_rx #(
    parameter int CLK_DIV     = 8,
    parameter int SLOT_BITS   = 32,
    parameter int DATA_BITS   = 8,
    parameter int NUM_SAMPLES = 4096,
    parameter int IDX_W       = 12
) (
    input logic            clk_i,
    input logic            rst_n_i,
    i2s_master_rx_if.master bus
);
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SLOT_W = $clog2(2 * SLOT_BITS);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(2 * SLOT_BITS - 1);
    localparam logic [SLOT_W-1:0] SLOT_RIGHT = SLOT_W'(SLOT_BITS);
    localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_SAMPLES - 1);

    typedef enum logic [2:0] {IDLE, ARM, SHIFT, EMIT, DONE} state_t;

    state_t               state;
    logic [DIV_W-1:0]     div_cnt;
    logic [SLOT_W-1:0]    slot_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [IDX_W-1:0]     idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 sck;
    logic                 ws;
    logic [DATA_BITS-1:0] sample;
    logic                 sample_valid;
    logic [IDX_W-1:0]     sample_idx;
    logic                 busy;
    logic                 done;
    logic                 sck_fall;
    logic                 ws_fall;

    // The edge that lowers sck is both the ws update edge and the data sampling edge.
    assign sck_fall = (div_cnt == DIV_LAST) && sck;
    // slot_cnt = 0 on a falling edge is exactly where ws drops into the left slot.
    assign ws_fall  = sck_fall && (slot_cnt == '0);

    // Free-running bit clock and word select, independent of any capture.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            div_cnt  <= '0;
            sck      <= 1'b0;
            slot_cnt <= '0;
            ws       <= 1'b1;
        end else begin
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                sck     <= ~sck;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (sck_fall) begin
                if (slot_cnt == '0) begin
                    ws <= 1'b0;
                end else if (slot_cnt == SLOT_RIGHT) begin
                    ws <= 1'b1;
                end
                slot_cnt <= (slot_cnt == SLOT_LAST) ? '0 : slot_cnt + 1'b1;
            end
        end
    end

    // Capture sequencer: arm on start, shift one left slot per frame, emit, repeat.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            idx          <= '0;
            shreg        <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            sample_idx   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            done         <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        state <= ARM;
                        busy  <= 1'b1;
                    end
                end
                ARM: begin
                    // The ws-fall edge itself carries no data bit.
                    if (ws_fall) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    if (sck_fall) begin
                        shreg   <= {shreg[DATA_BITS-2:0], bus.sd_i};
                        bit_cnt <= bit_cnt + 1'b1;
                        // Leave on the LSB edge so the strobe lands one clock later.
                        if (bit_cnt == BIT_LAST) begin
                            state <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    sample       <= shreg;
                    sample_valid <= 1'b1;
                    sample_idx   <= idx;
                    if (idx == IDX_LAST) begin
                        state <= DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= ARM;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    idx   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.sck_o          = sck;
    assign bus.ws_o           = ws;
    assign bus.LR_o           = 1'b0;
    assign bus.sample_o       = sample;
    assign bus.sample_valid_o = sample_valid;
    assign bus.sample_idx_o   = sample_idx;
    assign bus.busy_o         = busy;
    assign bus.done_o         = done;
endmodule

// File: tb/tb_i2s_master_rx.sv
// Directed bench for i2s_master_rx with a behavioural I2S microphone.
// Scaled parameters keep bursts short: sck period 8, frame 160 clocks.
module tb_i2s_master_rx;
    localparam int CLK_DIV     = 4;
    localparam int SLOT_BITS   = 10;
    localparam int DATA_BITS   = 8;
    localparam int NUM_SAMPLES = 16;
    localparam int IDX_W       = 4;
    localparam int SCK_PER     = 2 * CLK_DIV;
    localparam int FRAME       = 2 * SLOT_BITS * SCK_PER;
    localparam int LAT         = FRAME + DATA_BITS * SCK_PER + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc;
    int   done_cnt = 0;
    int   valid_cnt = 0;
    logic [7:0] mic_q[$];

    always #5 clk = ~clk;

    i2s_master_rx_if #(.DATA_BITS(DATA_BITS), .IDX_W(IDX_W)) bus();

    i2s_master_rx #(
        .CLK_DIV(CLK_DIV), .SLOT_BITS(SLOT_BITS), .DATA_BITS(DATA_BITS),
        .NUM_SAMPLES(NUM_SAMPLES), .IDX_W(IDX_W)
    ) dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .bus(bus)
    );

    // Clock edges since reset release; ws falls on edges 8 + 160k.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Strobe counters observed away from the active edge.
    always @(negedge clk) begin
        if (bus.done_o === 1'b1) done_cnt++;
        if (bus.sample_valid_o === 1'b1) valid_cnt++;
    end

    // Microphone: one queued word per left slot, MSB after the first rise, 1s elsewhere.
    logic       sck_prev;
    logic       ws_last;
    logic [7:0] cur_word;
    int         mic_bit;
    always @(negedge clk) begin
        if (!rst_n) begin
            sck_prev = 1'b0;
            ws_last  = 1'b1;
            mic_bit  = -1;
            cur_word = 8'h00;
            bus.sd_i = 1'b1;
        end else begin
            if (bus.sck_o && !sck_prev) begin
                if (!bus.ws_o && ws_last) begin
                    cur_word = 8'h00;
                    if (mic_q.size() > 0) cur_word = mic_q.pop_front();
                    mic_bit = DATA_BITS - 1;
                end else if (!bus.ws_o && mic_bit >= 0) begin
                    mic_bit--;
                end else begin
                    mic_bit = -1;
                end
                bus.sd_i = (mic_bit >= 0 && !bus.ws_o) ? cur_word[mic_bit] : 1'b1;
                ws_last  = bus.ws_o;
            end
            sck_prev = bus.sck_o;
        end
    end

    function automatic logic [7:0] pat(input int k);
        return 8'(k * 29 + 7);
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.start_i = 1'b0;
        mic_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
    endtask

    // Wait for a ws fall, then 20 clocks so the current frame's word is already taken.
    task automatic sync_mid_frame(output bit ok, output int t_fall);
        logic prev;
        ok = 1'b0;
        t_fall = 0;
        prev = bus.ws_o;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (prev === 1'b1 && bus.ws_o === 1'b0) begin
                ok = 1'b1;
                t_fall = cyc;
                break;
            end
            prev = bus.ws_o;
        end
        if (ok) repeat (20) @(negedge clk);
    endtask

    task automatic wait_strobe(output bit got, output int t);
        got = 1'b0;
        t = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.sample_valid_o === 1'b1) begin
                got = 1'b1;
                t = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int last_rise, last_fall, last_wrise, lr_bad;
        logic sp, wp;
        @(negedge clk);
        rst_n = 1'b0;
        bus.start_i = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.sck_o, bus.ws_o, bus.LR_o, bus.sample_o, bus.sample_valid_o,
             bus.sample_idx_o, bus.busy_o, bus.done_o} !== {1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_outputs: got sck=%b ws=%b lr=%b smp=%h v=%b idx=%h busy=%b done=%b want 0 1 0 00 0 0 0 0",
                     bus.sck_o, bus.ws_o, bus.LR_o, bus.sample_o, bus.sample_valid_o,
                     bus.sample_idx_o, bus.busy_o, bus.done_o);
        end
        rst_n = 1'b1;
        n_cmp++;
        if (bus.sck_o !== 1'b0 || bus.ws_o !== 1'b1) begin
            n_err++;
            $display("FAIL release_levels: got sck=%b ws=%b want sck=0 ws=1", bus.sck_o, bus.ws_o);
        end
        last_rise = 0; last_fall = 0; last_wrise = 0; lr_bad = 0;
        sp = bus.sck_o; wp = bus.ws_o;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (bus.LR_o !== 1'b0) lr_bad++;
            if (bus.sck_o === 1'b1 && sp === 1'b0) begin
                n_cmp++;
                if (last_rise == 0 && n != CLK_DIV) begin
                    n_err++;
                    $display("FAIL first_sck_rise: got edge %0d want %0d", n, CLK_DIV);
                end else if (last_rise != 0 && n - last_rise != SCK_PER) begin
                    n_err++;
                    $display("FAIL sck_period: got %0d want %0d", n - last_rise, SCK_PER);
                end
                last_rise = n;
            end
            if (bus.ws_o === 1'b0 && wp === 1'b1) begin
                n_cmp++;
                if (last_wrise == 0 && n != SCK_PER) begin
                    n_err++;
                    $display("FAIL first_ws_fall: got edge %0d want %0d", n, SCK_PER);
                end else if (last_wrise != 0 && n - last_wrise != FRAME / 2) begin
                    n_err++;
                    $display("FAIL ws_high_len: got %0d want %0d", n - last_wrise, FRAME / 2);
                end
                last_fall = n;
            end
            if (bus.ws_o === 1'b1 && wp === 1'b0) begin
                n_cmp++;
                if (n - last_fall != FRAME / 2) begin
                    n_err++;
                    $display("FAIL ws_low_len: got %0d want %0d", n - last_fall, FRAME / 2);
                end
                last_wrise = n;
            end
            sp = bus.sck_o;
            wp = bus.ws_o;
        end
        n_cmp++;
        if (lr_bad != 0) begin
            n_err++;
            $display("FAIL lr_const: got %0d cycles with LR=1 want 0", lr_bad);
        end
    endtask

    task automatic test_single_capture();
        bit ok, got;
        int t_fall, t1, t2;
        apply_reset();
        sync_mid_frame(ok, t_fall);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL single_sync: got no ws fall want one"); end
        mic_q.push_back(8'hA5);
        mic_q.push_back(8'h3C);
        n_cmp++;
        if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL single_busy_pre: got %b want 0", bus.busy_o); end
        pulse_start();
        n_cmp++;
        if (bus.busy_o !== 1'b1) begin n_err++; $display("FAIL single_busy_rise: got %b want 1", bus.busy_o); end
        wait_strobe(got, t1);
        n_cmp++;
        if (!got || bus.sample_o !== 8'hA5 || bus.sample_idx_o !== 4'd0) begin
            n_err++;
            $display("FAIL single_first: got seen=%0b smp=%h idx=%0d want smp=a5 idx=0", got, bus.sample_o, bus.sample_idx_o);
        end
        n_cmp++;
        if (t1 - t_fall != LAT) begin n_err++; $display("FAIL single_latency: got %0d want %0d", t1 - t_fall, LAT); end
        wait_strobe(got, t2);
        n_cmp++;
        if (!got || bus.sample_o !== 8'h3C || bus.sample_idx_o !== 4'd1) begin
            n_err++;
            $display("FAIL single_second: got seen=%0b smp=%h idx=%0d want smp=3c idx=1", got, bus.sample_o, bus.sample_idx_o);
        end
        n_cmp++;
        if (t2 - t1 != FRAME) begin n_err++; $display("FAIL single_spacing: got %0d want %0d", t2 - t1, FRAME); end
        @(negedge clk);
        n_cmp++;
        if (bus.sample_valid_o !== 1'b0 || bus.sample_o !== 8'h3C || bus.sample_idx_o !== 4'd1) begin
            n_err++;
            $display("FAIL single_hold: got v=%b smp=%h idx=%0d want v=0 smp=3c idx=1", bus.sample_valid_o, bus.sample_o, bus.sample_idx_o);
        end
    endtask

    task automatic test_start_during_burst();
        bit ok, got;
        int t_fall, t, d0;
        apply_reset();
        d0 = done_cnt;
        sync_mid_frame(ok, t_fall);
        for (int k = 0; k < NUM_SAMPLES; k++) mic_q.push_back(pat(k));
        pulse_start();
        for (int k = 0; k < 14; k++) begin
            wait_strobe(got, t);
            n_cmp++;
            if (!got || bus.sample_idx_o !== 4'(k) || bus.sample_o !== pat(k)) begin
                n_err++;
                $display("FAIL burst_start_ignored[%0d]: got seen=%0b idx=%0d smp=%h want idx=%0d smp=%h",
                         k, got, bus.sample_idx_o, bus.sample_o, k, pat(k));
            end
            if (k == 10) pulse_start();
        end
        n_cmp++;
        if (bus.busy_o !== 1'b1 || done_cnt != d0) begin
            n_err++;
            $display("FAIL burst_still_busy: got busy=%b dones=%0d want busy=1 dones=0", bus.busy_o, done_cnt - d0);
        end
    endtask

    task automatic test_full_burst();
        bit ok, got;
        int t_fall, t, d0;
        apply_reset();
        d0 = done_cnt;
        sync_mid_frame(ok, t_fall);
        for (int k = 0; k < NUM_SAMPLES; k++) mic_q.push_back(8'(255 - k * 13));
        pulse_start();
        for (int k = 0; k < NUM_SAMPLES; k++) begin
            wait_strobe(got, t);
            n_cmp++;
            if (!got || bus.sample_idx_o !== 4'(k) || bus.sample_o !== 8'(255 - k * 13)) begin
                n_err++;
                $display("FAIL full_sample[%0d]: got seen=%0b idx=%0d smp=%h want idx=%0d smp=%h",
                         k, got, bus.sample_idx_o, bus.sample_o, k, 8'(255 - k * 13));
            end
            n_cmp++;
            if (bus.done_o !== 1'b0) begin n_err++; $display("FAIL full_done_early[%0d]: got 1 want 0", k); end
        end
        @(negedge clk);
        n_cmp++;
        if (bus.done_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.sample_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL full_done: got done=%b busy=%b v=%b want done=1 busy=0 v=0", bus.done_o, bus.busy_o, bus.sample_valid_o);
        end
        repeat (50) @(negedge clk);
        n_cmp++;
        if (done_cnt - d0 != 1 || bus.busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL full_done_once: got dones=%0d busy=%b want dones=1 busy=0", done_cnt - d0, bus.busy_o);
        end
        n_cmp++;
        if (bus.sample_o !== 8'(255 - 15 * 13) || bus.sample_idx_o !== 4'd15) begin
            n_err++;
            $display("FAIL full_hold_after_done: got smp=%h idx=%0d want smp=%h idx=15", bus.sample_o, bus.sample_idx_o, 8'(255 - 15 * 13));
        end
        sync_mid_frame(ok, t_fall);
        mic_q.push_back(8'h81);
        pulse_start();
        wait_strobe(got, t);
        n_cmp++;
        if (!got || bus.sample_idx_o !== 4'd0 || bus.sample_o !== 8'h81) begin
            n_err++;
            $display("FAIL full_restart: got seen=%0b idx=%0d smp=%h want idx=0 smp=81", got, bus.sample_idx_o, bus.sample_o);
        end
    endtask

    task automatic test_start_coincident();
        bit got;
        int t, guard;
        apply_reset();
        guard = 0;
        while (cyc != 200 && guard < 1000) begin @(negedge clk); guard++; end
        mic_q.push_back(8'h5A);
        mic_q.push_back(8'hC3);
        while (cyc != 327 && guard < 1000) begin @(negedge clk); guard++; end
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        wait_strobe(got, t);
        n_cmp++;
        if (!got || t != 328 + LAT) begin
            n_err++;
            $display("FAIL coinc_time: got seen=%0b edge=%0d want edge=%0d", got, t, 328 + LAT);
        end
        n_cmp++;
        if (bus.sample_o !== 8'hC3 || bus.sample_idx_o !== 4'd0) begin
            n_err++;
            $display("FAIL coinc_sample: got smp=%h idx=%0d want smp=c3 idx=0", bus.sample_o, bus.sample_idx_o);
        end
    endtask

    task automatic test_reset_mid_burst();
        bit ok, got;
        int t_fall, t, d0, v0;
        apply_reset();
        sync_mid_frame(ok, t_fall);
        for (int k = 0; k < NUM_SAMPLES; k++) mic_q.push_back(pat(k));
        pulse_start();
        for (int k = 0; k <= 5; k++) wait_strobe(got, t);
        n_cmp++;
        if (!got || bus.sample_idx_o !== 4'd5) begin
            n_err++;
            $display("FAIL mid_reach5: got seen=%0b idx=%0d want idx=5", got, bus.sample_idx_o);
        end
        // Next ws fall is 95 clocks after the strobe; land 30 clocks into the shift.
        repeat (125) @(negedge clk);
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.sck_o, bus.ws_o, bus.LR_o, bus.sample_o, bus.sample_valid_o,
             bus.sample_idx_o, bus.busy_o, bus.done_o} !== {1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL mid_reset_outputs: got sck=%b ws=%b lr=%b smp=%h v=%b idx=%h busy=%b done=%b want 0 1 0 00 0 0 0 0",
                     bus.sck_o, bus.ws_o, bus.LR_o, bus.sample_o, bus.sample_valid_o,
                     bus.sample_idx_o, bus.busy_o, bus.done_o);
        end
        repeat (3) @(negedge clk);
        mic_q.delete();
        rst_n = 1'b1;
        v0 = valid_cnt;
        repeat (300) @(negedge clk);
        n_cmp++;
        if (done_cnt != d0 || valid_cnt != v0 || bus.busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL mid_no_tail: got dones=%0d strobes=%0d busy=%b want 0 0 0", done_cnt - d0, valid_cnt - v0, bus.busy_o);
        end
        sync_mid_frame(ok, t_fall);
        mic_q.push_back(8'h77);
        pulse_start();
        wait_strobe(got, t);
        n_cmp++;
        if (!got || bus.sample_idx_o !== 4'd0 || bus.sample_o !== 8'h77) begin
            n_err++;
            $display("FAIL mid_restart: got seen=%0b idx=%0d smp=%h want idx=0 smp=77", got, bus.sample_idx_o, bus.sample_o);
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        bus.start_i = 1'b0;
        test_reset();
        test_single_capture();
        test_start_during_burst();
        test_full_burst();
        test_start_coincident();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
